// File: rtl/psx_ddr_bridge_gen.sv
// PSX GPU memory client to Avalon-MM bridge.
// Turns one 32-byte-block client request into Avalon read/write traffic,
// either as a single burst command or as a sequence of single-beat commands.
// Only one client command is in flight at a time.
// Note: burstcount is 3 bits, so a 32-byte burst on a 32-bit bus (8 beats)
// does not fit; use BURST_MODE=0 with MEM_DATA_W=32.
module psx_ddr_bridge_gen #(
  parameter int MEM_DATA_W = 64,
  parameter int BLK_ADR_W  = 15,
  parameter int BURST_MODE = 1,
  parameter int SKIP_EMPTY = 0,
  localparam int BPB       = MEM_DATA_W / 8,
  localparam int NB32      = 32 / BPB,
  localparam int LOG_NB    = $clog2(NB32),
  localparam int LOG_BPB   = $clog2(BPB),
  localparam int MEM_ADR_W = BLK_ADR_W + LOG_NB
) (
  input  logic                  i_clk,
  input  logic                  i_nRst,
  input  logic                  i_command,
  input  logic                  i_writeElseRead,
  input  logic [1:0]            i_commandSize,
  input  logic [BLK_ADR_W-1:0]  i_targetAddr,
  input  logic [2:0]            i_subAddr,
  input  logic [15:0]           i_writeMask,
  input  logic [255:0]          i_dataClient,
  output logic                  o_busyClient,
  output logic                  o_dataValidClient,
  output logic [255:0]          o_dataClient,
  output logic [MEM_ADR_W-1:0]  o_targetAddr,
  output logic [2:0]            o_burstLength,
  input  logic                  i_busyMem,
  output logic                  o_writeEnableMem,
  output logic                  o_readEnableMem,
  output logic [MEM_DATA_W-1:0] o_dataMem,
  output logic [BPB-1:0]        o_byteEnableMem,
  input  logic                  i_dataValidMem,
  input  logic [MEM_DATA_W-1:0] i_dataMem
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_BEAT = 3'd3;
  localparam logic [2:0] S_RD_DONE = 3'd4;

  localparam int  N8          = (BPB >= 8) ? 1 : (8 / BPB);
  localparam bit  SKIP_ACTIVE = (SKIP_EMPTY != 0) && (BURST_MODE == 0);

  logic [2:0]            r_state;
  logic [3:0]            r_n, r_k, r_rcv;
  logic [4:0]            r_off;
  logic                  r_is4, r_is8;
  logic [MEM_ADR_W-1:0]  r_base;
  logic [255:0]          r_wdata, r_rdBuf;
  logic [31:0]           r_wbe;
  logic                  r_busy, r_valid, r_wr, r_rd;
  logic [255:0]          r_dataClient;
  logic [MEM_ADR_W-1:0]  r_addr;
  logic [2:0]            r_burst;
  logic [MEM_DATA_W-1:0] r_dmem;
  logic [BPB-1:0]        r_be;

  logic [4:0]            w_baddr, w_off;
  logic [3:0]            w_s, w_n;
  logic                  w_is4, w_is8;
  logic [MEM_ADR_W-1:0]  w_start;
  logic [31:0]           w_beFull, w_latBe;
  logic [255:0]          w_latData, w_rdAsm, w_rdShift, w_rdResult;
  logic [4:0]            w_first, w_next;

  // First beat index >= from and < n that should be issued; bit 4 = found.
  function automatic logic [4:0] next_beat(input logic [31:0] be, input logic [3:0] from,
                                           input logic [3:0] n);
    logic [4:0] res;
    res = 5'd0;
    for (int j = NB32 - 1; j >= 0; j--) begin
      if ((4'(j) >= from) && (4'(j) < n) && (!SKIP_ACTIVE || (be[j*BPB +: BPB] != '0)))
        res = {1'b1, 4'(j)};
    end
    return res;
  endfunction

  // Select the write data of beat k from the 32-byte staging buffer.
  function automatic logic [MEM_DATA_W-1:0] beat_data(input logic [255:0] d, input logic [3:0] k);
    logic [MEM_DATA_W-1:0] res;
    res = '0;
    for (int j = 0; j < NB32; j++) begin
      if (4'(j) == k) res = d[j*MEM_DATA_W +: MEM_DATA_W];
    end
    return res;
  endfunction

  // Select the byte enables of beat k from the 32-bit byte-enable vector.
  function automatic logic [BPB-1:0] beat_be(input logic [31:0] be, input logic [3:0] k);
    logic [BPB-1:0] res;
    res = '0;
    for (int j = 0; j < NB32; j++) begin
      if (4'(j) == k) res = be[j*BPB +: BPB];
    end
    return res;
  endfunction

  // Request decode, write lane placement and read assembly/extraction.
  always_comb begin
    w_baddr  = {i_subAddr, 2'b00};
    w_s      = 4'(w_baddr >> LOG_BPB);
    w_off    = w_baddr & 5'(BPB - 1);
    w_is4    = (i_commandSize == 2'd2);
    w_is8    = (i_commandSize == 2'd0);
    w_n      = w_is4 ? 4'd1 : (w_is8 ? 4'(N8) : 4'(NB32));
    w_start  = (MEM_ADR_W'(i_targetAddr) << LOG_NB) + MEM_ADR_W'(w_s);
    w_beFull = 32'd0;
    for (int b = 0; b < 32; b++) w_beFull[b] = i_writeMask[b/2];
    w_latBe  = (w_is4 || w_is8)
             ? ((w_beFull & (w_is4 ? 32'h0000_000F : 32'h0000_00FF)) << w_off)
             : w_beFull;
    w_latData = w_is4 ? ({224'd0, i_dataClient[31:0]} << {w_off, 3'b000})
              : (w_is8 ? ({192'd0, i_dataClient[63:0]} << {w_off, 3'b000}) : i_dataClient);
    w_first  = next_beat(w_latBe, 4'd0, w_n);
    w_next   = next_beat(r_wbe, r_k + 4'd1, r_n);
    w_rdAsm  = r_rdBuf;
    for (int j = 0; j < NB32; j++) begin
      if (4'(j) == r_rcv) w_rdAsm[j*MEM_DATA_W +: MEM_DATA_W] = i_dataMem;
    end
    w_rdShift  = w_rdAsm >> {r_off, 3'b000};
    w_rdResult = r_is4 ? {224'd0, w_rdShift[31:0]}
               : (r_is8 ? {192'd0, w_rdShift[63:0]} : w_rdAsm);
  end

  // Main control FSM with registered client and Avalon outputs.
  always_ff @(posedge i_clk) begin
    if (!i_nRst) begin
      r_state <= S_IDLE;  r_n <= 4'd0;   r_k <= 4'd0;    r_rcv <= 4'd0;
      r_off <= 5'd0;      r_is4 <= 1'b0; r_is8 <= 1'b0;  r_base <= '0;
      r_wdata <= 256'd0;  r_rdBuf <= 256'd0;  r_wbe <= 32'd0;
      r_busy <= 1'b0;     r_valid <= 1'b0;    r_wr <= 1'b0;  r_rd <= 1'b0;
      r_dataClient <= 256'd0;  r_addr <= '0;  r_burst <= 3'd0;
      r_dmem <= '0;       r_be <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_command) begin
            r_busy <= 1'b1;  r_n <= w_n;  r_rcv <= 4'd0;  r_off <= w_off;
            r_is4 <= w_is4;  r_is8 <= w_is8;  r_base <= w_start;
            r_wdata <= w_latData;  r_wbe <= w_latBe;  r_rdBuf <= 256'd0;
            r_burst <= (BURST_MODE != 0) ? 3'(w_n) : 3'd1;
            if (!i_writeElseRead) begin
              r_state <= S_RD_REQ;
              r_rd    <= 1'b1;
              r_k     <= 4'd0;
              r_addr  <= w_start;
            end else begin
              r_state <= S_WR_BEAT;
              r_wr    <= w_first[4];
              r_k     <= w_first[3:0];
              r_addr  <= (BURST_MODE != 0) ? w_start : (w_start + MEM_ADR_W'(w_first[3:0]));
              r_dmem  <= beat_data(w_latData, w_first[3:0]);
              r_be    <= beat_be(w_latBe, w_first[3:0]);
            end
          end
        end
        S_RD_REQ, S_RD_WAIT: begin
          if (i_dataValidMem) begin
            r_rdBuf <= w_rdAsm;
            r_rcv   <= r_rcv + 4'd1;
          end
          if (i_dataValidMem && ((r_rcv + 4'd1) == r_n)) begin
            r_state      <= S_RD_DONE;
            r_rd         <= 1'b0;
            r_valid      <= 1'b1;
            r_dataClient <= w_rdResult;
          end else if ((r_state == S_RD_REQ) && !i_busyMem) begin
            if ((BURST_MODE != 0) || ((r_k + 4'd1) == r_n)) begin
              r_state <= S_RD_WAIT;
              r_rd    <= 1'b0;
            end else begin
              r_k    <= r_k + 4'd1;
              r_addr <= r_base + MEM_ADR_W'(r_k + 4'd1);
            end
          end
        end
        S_RD_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_WR_BEAT: begin
          if (!r_wr) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (!i_busyMem) begin
            if (w_next[4]) begin
              r_k    <= w_next[3:0];
              r_dmem <= beat_data(r_wdata, w_next[3:0]);
              r_be   <= beat_be(r_wbe, w_next[3:0]);
              if (BURST_MODE == 0) r_addr <= r_base + MEM_ADR_W'(w_next[3:0]);
            end else begin
              r_wr    <= 1'b0;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_wr    <= 1'b0;
          r_rd    <= 1'b0;
        end
      endcase
    end
  end

  assign o_busyClient      = r_busy;
  assign o_dataValidClient = r_valid;
  assign o_dataClient      = r_dataClient;
  assign o_targetAddr      = r_addr;
  assign o_burstLength     = r_burst;
  assign o_writeEnableMem  = r_wr;
  assign o_readEnableMem   = r_rd;
  assign o_dataMem         = r_dmem;
  assign o_byteEnableMem   = r_be;

endmodule

// File: tb/tb_psx_ddr_bridge_gen.sv
// Directed self-checking bench: instance A is burst mode, instance B is
// single-beat mode with empty-beat skipping. They share every input except
// the command strobe, so only the addressed instance acts.
module tb_psx_ddr_bridge_gen;
  logic         clk = 1'b0;
  logic         nRst, cmd_a, cmd_b, wer, busyMem, dvm;
  logic [1:0]   sz;
  logic [14:0]  tadr;
  logic [2:0]   sub;
  logic [15:0]  mask;
  logic [255:0] dcl;
  logic [63:0]  dmem;
  logic         busy_a, vld_a, wr_a, rd_a, busy_b, vld_b, wr_b, rd_b;
  logic [255:0] dcl_a, dcl_b;
  logic [16:0]  adr_a, adr_b;
  logic [2:0]   bl_a, bl_b;
  logic [63:0]  dm_a, dm_b;
  logic [7:0]   be_a, be_b;
  int           pass_cnt = 0;
  int           total_cnt = 0;

  always #5 clk = ~clk;

  psx_ddr_bridge_gen #(.MEM_DATA_W(64), .BLK_ADR_W(15), .BURST_MODE(1), .SKIP_EMPTY(0)) u_a (
    .i_clk(clk), .i_nRst(nRst), .i_command(cmd_a), .i_writeElseRead(wer),
    .i_commandSize(sz), .i_targetAddr(tadr), .i_subAddr(sub), .i_writeMask(mask),
    .i_dataClient(dcl), .o_busyClient(busy_a), .o_dataValidClient(vld_a),
    .o_dataClient(dcl_a), .o_targetAddr(adr_a), .o_burstLength(bl_a),
    .i_busyMem(busyMem), .o_writeEnableMem(wr_a), .o_readEnableMem(rd_a),
    .o_dataMem(dm_a), .o_byteEnableMem(be_a), .i_dataValidMem(dvm), .i_dataMem(dmem));

  psx_ddr_bridge_gen #(.MEM_DATA_W(64), .BLK_ADR_W(15), .BURST_MODE(0), .SKIP_EMPTY(1)) u_b (
    .i_clk(clk), .i_nRst(nRst), .i_command(cmd_b), .i_writeElseRead(wer),
    .i_commandSize(sz), .i_targetAddr(tadr), .i_subAddr(sub), .i_writeMask(mask),
    .i_dataClient(dcl), .o_busyClient(busy_b), .o_dataValidClient(vld_b),
    .o_dataClient(dcl_b), .o_targetAddr(adr_b), .o_burstLength(bl_b),
    .i_busyMem(busyMem), .o_writeEnableMem(wr_b), .o_readEnableMem(rd_b),
    .o_dataMem(dm_b), .o_byteEnableMem(be_b), .i_dataValidMem(dvm), .i_dataMem(dmem));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic sel_b, input logic wr, input logic [1:0] s,
                       input logic [14:0] blk, input logic [2:0] sa,
                       input logic [15:0] m, input logic [255:0] d);
    wer = wr; sz = s; tadr = blk; sub = sa; mask = m; dcl = d;
    if (sel_b) cmd_b = 1'b1; else cmd_a = 1'b1;
    step();
    cmd_a = 1'b0; cmd_b = 1'b0;
  endtask

  task automatic test_reset();
    nRst = 1'b0; step(); step();
    @(negedge clk);
    total_cnt++;
    if ({busy_a, vld_a, rd_a, wr_a} !== 4'b0000)
      $display("FAIL reset_strobes: busy/vld/rd/wr=%b, want 0000", {busy_a, vld_a, rd_a, wr_a});
    else pass_cnt++;
    total_cnt++;
    if (dcl_a !== 256'd0) $display("FAIL reset_data: got %h, want 0", dcl_a);
    else pass_cnt++;
    total_cnt++;
    if ({busy_b, vld_b, rd_b, wr_b} !== 4'b0000)
      $display("FAIL reset_strobes_b: got %b, want 0000", {busy_b, vld_b, rd_b, wr_b});
    else pass_cnt++;
    nRst = 1'b1; step();
  endtask

  task automatic burst_read32(input logic [14:0] blk, input logic [16:0] exp_adr, input string nm);
    logic [63:0]  beats [4];
    logic [255:0] exp;
    for (int i = 0; i < 4; i++) beats[i] = {blk, 17'h0A5A5, 8'(i), 24'hC0FFEE};
    exp = {beats[3], beats[2], beats[1], beats[0]};
    issue(1'b0, 1'b0, 2'd1, blk, 3'd0, 16'h0000, 256'd0);
    @(negedge clk);
    total_cnt++;
    if (rd_a !== 1'b1 || adr_a !== exp_adr || bl_a !== 3'd4 || busy_a !== 1'b1)
      $display("FAIL %s_cmd: rd=%b adr=%h bl=%0d busy=%b, want rd=1 adr=%h bl=4 busy=1",
               nm, rd_a, adr_a, bl_a, busy_a, exp_adr);
    else pass_cnt++;
    step();
    for (int i = 0; i < 4; i++) begin
      dvm = 1'b1; dmem = beats[i];
      @(negedge clk);
      total_cnt++;
      if (rd_a !== 1'b0 || vld_a !== 1'b0)
        $display("FAIL %s_beat%0d: rd=%b vld=%b, want 0 0", nm, i, rd_a, vld_a);
      else pass_cnt++;
      step();
    end
    dvm = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (vld_a !== 1'b1 || dcl_a !== exp)
      $display("FAIL %s_done: vld=%b data=%h, want vld=1 data=%h", nm, vld_a, dcl_a, exp);
    else pass_cnt++;
    step();
    @(negedge clk);
    total_cnt++;
    if (vld_a !== 1'b0 || busy_a !== 1'b0 || dcl_a !== exp)
      $display("FAIL %s_after: vld=%b busy=%b data=%h, want 0 0 held", nm, vld_a, busy_a, dcl_a);
    else pass_cnt++;
    step();
  endtask

  task automatic test_read32();
    burst_read32(15'h1234, 17'h048D0, "read32");
  endtask

  task automatic test_read4();
    issue(1'b0, 1'b0, 2'd2, 15'h1234, 3'd3, 16'h0000, 256'd0);
    @(negedge clk);
    total_cnt++;
    if (rd_a !== 1'b1 || adr_a !== 17'h048D1 || bl_a !== 3'd1)
      $display("FAIL read4_cmd: rd=%b adr=%h bl=%0d, want 1 048d1 1", rd_a, adr_a, bl_a);
    else pass_cnt++;
    step();
    dvm = 1'b1; dmem = 64'h1122_3344_5566_7788;
    step();
    dvm = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (vld_a !== 1'b1 || dcl_a !== 256'h1122_3344)
      $display("FAIL read4_data: vld=%b data=%h, want 1 11223344", vld_a, dcl_a);
    else pass_cnt++;
    step(); step();
  endtask

  task automatic test_write4();
    issue(1'b0, 1'b1, 2'd2, 15'h1234, 3'd5, 16'h0003, 256'hDEAD_BEEF);
    @(negedge clk);
    total_cnt++;
    if (wr_a !== 1'b1 || adr_a !== 17'h048D2 || dm_a[63:32] !== 32'hDEAD_BEEF ||
        be_a !== 8'hF0 || bl_a !== 3'd1)
      $display("FAIL write4_beat: wr=%b adr=%h dm=%h be=%h bl=%0d, want 1 048d2 deadbeef_xxxxxxxx f0 1",
               wr_a, adr_a, dm_a, be_a, bl_a);
    else pass_cnt++;
    step();
    @(negedge clk);
    total_cnt++;
    if (wr_a !== 1'b0 || busy_a !== 1'b0)
      $display("FAIL write4_end: wr=%b busy=%b, want 0 0", wr_a, busy_a);
    else pass_cnt++;
    step();
  endtask

  task automatic test_write32_wait();
    logic [63:0]  d [4];
    logic [7:0]   be [4];
    logic [255:0] dd;
    int           acc;
    int           cyc;
    be[0] = 8'h03; be[1] = 8'hC0; be[2] = 8'hF0; be[3] = 8'h0F;
    for (int i = 0; i < 4; i++) d[i] = {32'hA5A5_0000, 24'h0, 8'(i + 1)};
    dd = {d[3], d[2], d[1], d[0]};
    acc = 0;
    issue(1'b0, 1'b1, 2'd1, 15'h0ABC, 3'd0, 16'h3C81, dd);
    for (int k = 0; k < 4; k++) begin
      cyc = (k == 2) ? 4 : 1;
      for (int c = 0; c < cyc; c++) begin
        busyMem = (c < cyc - 1);
        @(negedge clk);
        total_cnt++;
        if (wr_a !== 1'b1 || adr_a !== 17'h02AF0 || dm_a !== d[k] || be_a !== be[k] || bl_a !== 3'd4)
          $display("FAIL write32_beat%0d_c%0d: wr=%b adr=%h dm=%h be=%h bl=%0d, want 1 02af0 %h %h 4",
                   k, c, wr_a, adr_a, dm_a, be_a, bl_a, d[k], be[k]);
        else pass_cnt++;
        if (wr_a && !busyMem) acc++;
        step();
      end
    end
    busyMem = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (acc !== 4 || wr_a !== 1'b0 || busy_a !== 1'b0)
      $display("FAIL write32_end: accepts=%0d wr=%b busy=%b, want 4 0 0", acc, wr_a, busy_a);
    else pass_cnt++;
    step();
  endtask

  task automatic test_skip();
    int           n;
    logic [16:0]  a;
    logic [7:0]   b;
    logic [63:0]  d;
    n = 0; a = '0; b = '0; d = '0;
    issue(1'b1, 1'b1, 2'd1, 15'h0010, 3'd0, 16'h00F0,
          256'h4444_4444_4444_4444_3333_3333_3333_3333_2222_2222_2222_2222_1111_1111_1111_1111);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wr_b) begin n++; a = adr_b; b = be_b; d = dm_b; end
      step();
    end
    total_cnt++;
    if (n !== 1 || a !== 17'h00041 || b !== 8'hFF || d !== 64'h2222_2222_2222_2222 || busy_b !== 1'b0)
      $display("FAIL skip_one: writes=%0d adr=%h be=%h dm=%h busy=%b, want 1 00041 ff 2222222222222222 0",
               n, a, b, d, busy_b);
    else pass_cnt++;
    n = 0;
    issue(1'b1, 1'b1, 2'd1, 15'h0010, 3'd0, 16'h0000, 256'd0);
    @(negedge clk);
    if (wr_b || rd_b) n++;
    total_cnt++;
    if (busy_b !== 1'b1) $display("FAIL skip_empty_busy: busy=%b, want 1", busy_b);
    else pass_cnt++;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wr_b || rd_b || busy_b) n++;
      step();
    end
    total_cnt++;
    if (n !== 0) $display("FAIL skip_empty_idle: activity cycles=%0d, want 0", n);
    else pass_cnt++;
  endtask

  task automatic test_single_read();
    logic [63:0]  beats [4];
    logic [255:0] exp;
    for (int i = 0; i < 4; i++) beats[i] = {32'h5EED_0000, 24'h0, 8'(i + 8'h10)};
    exp = {beats[3], beats[2], beats[1], beats[0]};
    issue(1'b1, 1'b0, 2'd1, 15'h0010, 3'd0, 16'h0000, 256'd0);
    for (int i = 0; i < 4; i++) begin
      dvm = (i > 0);
      if (i > 0) dmem = beats[i - 1];
      @(negedge clk);
      total_cnt++;
      if (rd_b !== 1'b1 || adr_b !== (17'h00040 + 17'(i)) || bl_b !== 3'd1)
        $display("FAIL single_rd%0d: rd=%b adr=%h bl=%0d, want 1 %h 1",
                 i, rd_b, adr_b, bl_b, 17'h00040 + 17'(i));
      else pass_cnt++;
      step();
    end
    dvm = 1'b1; dmem = beats[3];
    @(negedge clk);
    total_cnt++;
    if (rd_b !== 1'b0 || vld_b !== 1'b0)
      $display("FAIL single_wait: rd=%b vld=%b, want 0 0", rd_b, vld_b);
    else pass_cnt++;
    step();
    dvm = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (vld_b !== 1'b1 || dcl_b !== exp)
      $display("FAIL single_done: vld=%b data=%h, want 1 %h", vld_b, dcl_b, exp);
    else pass_cnt++;
    step(); step();
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    issue(1'b0, 1'b0, 2'd1, 15'h0200, 3'd0, 16'h0000, 256'd0);
    step();
    dvm = 1'b1; dmem = 64'hBAD0_0000_0000_0000; step();
    dmem = 64'hBAD0_0000_0000_0001; step();
    dvm = 1'b0; nRst = 1'b0;
    step();
    @(negedge clk);
    total_cnt++;
    if (busy_a !== 1'b0 || vld_a !== 1'b0 || rd_a !== 1'b0 || dcl_a !== 256'd0)
      $display("FAIL rstmid_abort: busy=%b vld=%b rd=%b data=%h, want 0 0 0 0",
               busy_a, vld_a, rd_a, dcl_a);
    else pass_cnt++;
    nRst = 1'b1;
    step();
    dvm = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dmem = 64'hBAD0_0000_0000_0002 + 64'(i);
      step();
    end
    dvm = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (vld_a || busy_a) stray++;
      step();
    end
    total_cnt++;
    if (stray !== 0) $display("FAIL rstmid_stray: cycles with vld/busy=%0d, want 0", stray);
    else pass_cnt++;
    burst_read32(15'h0201, 17'h00804, "rstmid_next");
  endtask

  initial begin
    nRst = 1'b0; cmd_a = 1'b0; cmd_b = 1'b0; wer = 1'b0; busyMem = 1'b0; dvm = 1'b0;
    sz = 2'd0; tadr = 15'd0; sub = 3'd0; mask = 16'd0; dcl = 256'd0; dmem = 64'd0;
    step();
    test_reset();
    test_read32();
    test_read4();
    test_write4();
    test_write32_wait();
    test_skip();
    test_single_read();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
